// File: rtl/enc_pkg.sv
// Shared definitions for the quadrature encoder bank: Gray state codes, step codes
// and the prev/cur transition classifier used by every channel.
package enc_pkg;

    localparam logic [1:0] S00 = 2'b00;
    localparam logic [1:0] S01 = 2'b01;
    localparam logic [1:0] S11 = 2'b11;
    localparam logic [1:0] S10 = 2'b10;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2,
        STEP_ERR  = 2'd3
    } step_e;

    // States are {a,b}; CW order is 00 -> 01 -> 11 -> 10 -> 00.
    function automatic step_e decode_step(input logic [1:0] prev,
                                          input logic [1:0] cur,
                                          input logic       x4);
        step_e s;
        logic  up;
        s  = STEP_NONE;
        up = ((prev == S00) && (cur == S01)) || ((prev == S01) && (cur == S11)) ||
             ((prev == S11) && (cur == S10)) || ((prev == S10) && (cur == S00));
        if ((prev ^ cur) == 2'b11) begin
            s = STEP_ERR;
        end else if (prev != cur) begin
            if (x4 || (cur == S00)) begin
                s = up ? STEP_UP : STEP_DOWN;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/enc_channel.sv
// One encoder channel: 2-flop sync, tick-sampled debounce, Gray decode, bounded counter.
// Step acceleration is built only when ENC_ACCEL_EN is defined.
module enc_channel
    import enc_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               DB_LEN    = 4,
    parameter int               X4        = 1,
    parameter int               WRAP      = 1,
    parameter logic [WIDTH-1:0] MIN_VAL   = '0,
    parameter logic [WIDTH-1:0] MAX_VAL   = '1,
    parameter logic [WIDTH-1:0] INIT_VAL  = '0,
    parameter int               ACCEL_WIN = 8,
    parameter int               ACCEL_MUL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_tick,
    input  logic             a,
    input  logic             b,
    input  logic             clear,
    output logic [WIDTH-1:0] value,
    output logic             step_p,
    output logic             dir,
    output logic             err_p
);

    logic [1:0]       w_pin;
    logic [1:0]       w_acc;
    step_e            w_step;
    logic             w_is_step;
    logic [WIDTH:0]   w_mag;
    logic [WIDTH:0]   w_up;
    logic [WIDTH:0]   w_dn;
    logic [WIDTH:0]   w_next;
    logic [1:0]       r_prev;
    logic [WIDTH-1:0] r_value;
    logic             r_step_p;
    logic             r_dir;
    logic             r_err_p;

    assign w_pin = {a, b};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_pin
            logic [1:0]        r_sync;
            logic [DB_LEN-1:0] r_sh;
            logic              r_acc;

            // Accepted level only moves once the whole sample window agrees.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync <= 2'b11;
                    r_sh   <= '1;
                    r_acc  <= 1'b1;
                end else begin
                    r_sync <= {r_sync[0], w_pin[gi]};
                    if (i_tick) r_sh <= {r_sh[DB_LEN-2:0], r_sync[1]};
                    if (&r_sh)       r_acc <= 1'b1;
                    else if (~|r_sh) r_acc <= 1'b0;
                end
            end

            assign w_acc[gi] = r_acc;
        end
    endgenerate

    assign w_step    = decode_step(r_prev, w_acc, X4 != 0);
    assign w_is_step = (w_step == STEP_UP) || (w_step == STEP_DOWN);

`ifdef ENC_ACCEL_EN
    localparam int CW = $clog2(ACCEL_WIN + 1);
    logic [CW-1:0] r_since;

    // Starts saturated so the first step after reset is never accelerated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_since <= CW'(ACCEL_WIN);
        end else if (clear || w_is_step) begin
            r_since <= '0;
        end else if (i_tick && (r_since < CW'(ACCEL_WIN))) begin
            r_since <= r_since + 1'b1;
        end
    end

    assign w_mag = (r_since < CW'(ACCEL_WIN)) ? (WIDTH+1)'(ACCEL_MUL) : (WIDTH+1)'(1);
`else
    assign w_mag = (WIDTH+1)'(1);
`endif

    assign w_up = {1'b0, r_value} + w_mag;
    assign w_dn = {1'b0, r_value} - w_mag;

    // A borrow out of the subtraction sets the extra top bit.
    always_comb begin
        w_next = {1'b0, r_value};
        if (w_step == STEP_UP) begin
            if (w_up > {1'b0, MAX_VAL}) w_next = (WRAP != 0) ? {1'b0, MIN_VAL} : {1'b0, MAX_VAL};
            else                        w_next = w_up;
        end else if (w_step == STEP_DOWN) begin
            if (w_dn[WIDTH] || (w_dn < {1'b0, MIN_VAL}))
                w_next = (WRAP != 0) ? {1'b0, MAX_VAL} : {1'b0, MIN_VAL};
            else
                w_next = w_dn;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev   <= S11;
            r_value  <= INIT_VAL;
            r_step_p <= 1'b0;
            r_dir    <= 1'b0;
            r_err_p  <= 1'b0;
        end else begin
            r_prev   <= w_acc;
            r_err_p  <= (w_step == STEP_ERR);
            r_step_p <= 1'b0;
            if (clear) begin
                r_value <= INIT_VAL;
            end else if (w_is_step) begin
                r_value  <= w_next[WIDTH-1:0];
                r_step_p <= 1'b1;
                r_dir    <= (w_step == STEP_UP);
            end
        end
    end

    assign value  = r_value;
    assign step_p = r_step_p;
    assign dir    = r_dir;
    assign err_p  = r_err_p;

endmodule

// File: rtl/quad_encoder_bank.sv
// N-channel quadrature encoder front end: one shared debounce tick divider fanned out to
// N_CH enc_channel instances. Optional step acceleration via ENC_ACCEL_EN.
module quad_encoder_bank
    import enc_pkg::*;
#(
    parameter int               N_CH      = 2,
    parameter int               WIDTH     = 16,
    parameter int               DB_DIV    = 256,
    parameter int               DB_LEN    = 4,
    parameter int               X4        = 1,
    parameter int               WRAP      = 1,
    parameter logic [WIDTH-1:0] MIN_VAL   = '0,
    parameter logic [WIDTH-1:0] MAX_VAL   = '1,
    parameter logic [WIDTH-1:0] INIT_VAL  = '0,
    parameter int               ACCEL_WIN = 8,
    parameter int               ACCEL_MUL = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       a,
    input  logic [N_CH-1:0]       b,
    input  logic [N_CH-1:0]       clear,
    output logic [N_CH*WIDTH-1:0] value,
    output logic [N_CH-1:0]       step_p,
    output logic [N_CH-1:0]       dir,
    output logic [N_CH-1:0]       err_p
);

    localparam int DW = $clog2(DB_DIV);

    logic [DW-1:0] r_div;
    logic          r_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else if (r_div == DW'(DB_DIV - 1)) begin
            r_div  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_div  <= r_div + 1'b1;
            r_tick <= 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            enc_channel #(
                .WIDTH    (WIDTH),
                .DB_LEN   (DB_LEN),
                .X4       (X4),
                .WRAP     (WRAP),
                .MIN_VAL  (MIN_VAL),
                .MAX_VAL  (MAX_VAL),
                .INIT_VAL (INIT_VAL),
                .ACCEL_WIN(ACCEL_WIN),
                .ACCEL_MUL(ACCEL_MUL)
            ) u_ch (
                .clk   (clk),
                .rst_n (rst_n),
                .i_tick(r_tick),
                .a     (a[gi]),
                .b     (b[gi]),
                .clear (clear[gi]),
                .value (value[gi*WIDTH +: WIDTH]),
                .step_p(step_p[gi]),
                .dir   (dir[gi]),
                .err_p (err_p[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_quad_encoder_bank.sv
// Bench for quad_encoder_bank: three configurations (x4/wrap, x4/saturate, x1/wrap) share inputs;
// directed vector table, glitch and reset sequences, then random moves against a Gray-position model.
module tb_quad_encoder_bank;

    localparam int HOLD = 40;
    localparam int IDLE = 48;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  a, b, clear;
    logic [15:0] val_a, val_b, val_c;
    logic [1:0]  stp_a, stp_b, stp_c, dir_a, dir_b, dir_c, err_a, err_b, err_c;
    logic [15:0] val [3];
    logic [1:0]  stp [3];
    logic [1:0]  dr  [3];
    logic [1:0]  er  [3];

    assign val[0] = val_a; assign val[1] = val_b; assign val[2] = val_c;
    assign stp[0] = stp_a; assign stp[1] = stp_b; assign stp[2] = stp_c;
    assign dr[0]  = dir_a; assign dr[1]  = dir_b; assign dr[2]  = dir_c;
    assign er[0]  = err_a; assign er[1]  = err_b; assign er[2]  = err_c;

    always #5 clk = ~clk;

    quad_encoder_bank #(.N_CH(2), .WIDTH(8), .DB_DIV(4), .DB_LEN(4), .X4(1), .WRAP(1),
        .MIN_VAL(8'd0), .MAX_VAL(8'd9), .INIT_VAL(8'd0), .ACCEL_WIN(8), .ACCEL_MUL(4)) u_a (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .clear(clear),
        .value(val_a), .step_p(stp_a), .dir(dir_a), .err_p(err_a));
    quad_encoder_bank #(.N_CH(2), .WIDTH(8), .DB_DIV(4), .DB_LEN(4), .X4(1), .WRAP(0),
        .MIN_VAL(8'd0), .MAX_VAL(8'd9), .INIT_VAL(8'd0), .ACCEL_WIN(8), .ACCEL_MUL(4)) u_b (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .clear(clear),
        .value(val_b), .step_p(stp_b), .dir(dir_b), .err_p(err_b));
    quad_encoder_bank #(.N_CH(2), .WIDTH(8), .DB_DIV(4), .DB_LEN(4), .X4(0), .WRAP(1),
        .MIN_VAL(8'd0), .MAX_VAL(8'd255), .INIT_VAL(8'd0), .ACCEL_WIN(8), .ACCEL_MUL(4)) u_c (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .clear(clear),
        .value(val_c), .step_p(stp_c), .dir(dir_c), .err_p(err_c));

    // Model configuration per DUT: x4 decode, wrap, upper bound (lower bound and init are 0).
    int   cfg_x4   [3] = '{1, 1, 0};
    int   cfg_wrap [3] = '{1, 0, 1};
    int   cfg_max  [3] = '{9, 9, 255};

    int         tests = 0;
    int         fails = 0;
    logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    logic [1:0] st [2];
    int         m_val [3][2];
    int         m_dir [3][2];
    int         exp_val [3][2];
    int         exp_steps [3][2];
    int         exp_errs [3][2];
    int         cnt_steps [3][2];
    int         cnt_errs [3][2];

    typedef struct {
        logic [1:0] ab0;
        logic [1:0] ab1;
        logic [1:0] clr;
        int va0, vb0, vc0;
        int va1, vb1, vc1;
    } vec_t;
    vec_t tbl [23];

    function automatic int gpos(input logic [1:0] ab);
        for (int i = 0; i < 4; i++) if (gray[i] == ab) return i;
        return 0;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic zero_counts();
        for (int k = 0; k < 3; k++) for (int c = 0; c < 2; c++) begin
            cnt_steps[k][c] = 0; cnt_errs[k][c] = 0;
        end
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) for (int c = 0; c < 2; c++) begin
                cnt_steps[k][c] += int'(stp[k][c]);
                cnt_errs[k][c]  += int'(er[k][c]);
            end
        end
    endtask

    // Spec-level model: Gray position difference 1 = up, 3 = down, 2 = illegal.
    task automatic model_move(input logic [1:0] ab0, input logic [1:0] ab1, input logic [1:0] clr);
        for (int c = 0; c < 2; c++) begin
            logic [1:0] cur;
            int d;
            cur = (c == 0) ? ab0 : ab1;
            d = (gpos(cur) - gpos(st[c]) + 4) % 4;
            for (int k = 0; k < 3; k++) begin
                bit stepping;
                exp_steps[k][c] = 0;
                exp_errs[k][c]  = (d == 2) ? 1 : 0;
                stepping = (d == 1) || (d == 3);
                if (cfg_x4[k] == 0 && cur != 2'b00) stepping = 0;
                if (clr[c]) begin
                    m_val[k][c] = 0;
                end else if (stepping) begin
                    exp_steps[k][c] = 1;
                    m_dir[k][c] = (d == 1) ? 1 : 0;
                    if (d == 1) m_val[k][c] = (m_val[k][c] + 1 > cfg_max[k]) ?
                                              ((cfg_wrap[k] != 0) ? 0 : cfg_max[k]) : m_val[k][c] + 1;
                    else        m_val[k][c] = (m_val[k][c] - 1 < 0) ?
                                              ((cfg_wrap[k] != 0) ? cfg_max[k] : 0) : m_val[k][c] - 1;
                end
            end
            st[c] = cur;
        end
    endtask

    task automatic apply(input logic [1:0] ab0, input logic [1:0] ab1, input logic [1:0] clr);
        a = {ab1[1], ab0[1]};
        b = {ab1[0], ab0[0]};
        clear = clr;
        zero_counts();
        run_cycles(HOLD);
        if (clr != 2'b00) begin
            clear = 2'b00;
            run_cycles(IDLE);
        end
        model_move(ab0, ab1, clr);
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 3; k++) for (int c = 0; c < 2; c++) begin
            chk($sformatf("%s dut%0d ch%0d value", tag, k, c), int'(val[k][c*8 +: 8]), exp_val[k][c]);
            chk($sformatf("%s dut%0d ch%0d dir", tag, k, c), int'(dr[k][c]), m_dir[k][c]);
            chk($sformatf("%s dut%0d ch%0d steps", tag, k, c), cnt_steps[k][c], exp_steps[k][c]);
            chk($sformatf("%s dut%0d ch%0d errs", tag, k, c), cnt_errs[k][c], exp_errs[k][c]);
        end
    endtask

    task automatic model_to_exp();
        for (int k = 0; k < 3; k++) for (int c = 0; c < 2; c++) exp_val[k][c] = m_val[k][c];
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //        ab0    ab1    clr    ch0 a,b,c    ch1 a,b,c
        tbl[0]  = '{2'b10, 2'b11, 2'b00, 1, 1, 0,   0, 0, 0};
        tbl[1]  = '{2'b00, 2'b11, 2'b00, 2, 2, 1,   0, 0, 0};
        tbl[2]  = '{2'b01, 2'b11, 2'b00, 3, 3, 1,   0, 0, 0};
        tbl[3]  = '{2'b11, 2'b11, 2'b00, 4, 4, 1,   0, 0, 0};
        tbl[4]  = '{2'b10, 2'b11, 2'b00, 5, 5, 1,   0, 0, 0};
        tbl[5]  = '{2'b00, 2'b11, 2'b00, 6, 6, 2,   0, 0, 0};
        tbl[6]  = '{2'b01, 2'b11, 2'b00, 7, 7, 2,   0, 0, 0};
        tbl[7]  = '{2'b11, 2'b11, 2'b00, 8, 8, 2,   0, 0, 0};
        tbl[8]  = '{2'b10, 2'b11, 2'b00, 9, 9, 2,   0, 0, 0};
        tbl[9]  = '{2'b00, 2'b11, 2'b00, 0, 9, 3,   0, 0, 0};
        tbl[10] = '{2'b10, 2'b11, 2'b00, 9, 8, 3,   0, 0, 0};
        tbl[11] = '{2'b11, 2'b11, 2'b00, 8, 7, 3,   0, 0, 0};
        tbl[12] = '{2'b01, 2'b11, 2'b00, 7, 6, 3,   0, 0, 0};
        tbl[13] = '{2'b00, 2'b11, 2'b00, 6, 5, 2,   0, 0, 0};
        tbl[14] = '{2'b11, 2'b11, 2'b00, 6, 5, 2,   0, 0, 0};
        tbl[15] = '{2'b11, 2'b11, 2'b01, 0, 0, 0,   0, 0, 0};
        tbl[16] = '{2'b01, 2'b11, 2'b00, 9, 0, 0,   0, 0, 0};
        tbl[17] = '{2'b00, 2'b11, 2'b00, 8, 0, 255, 0, 0, 0};
        tbl[18] = '{2'b01, 2'b11, 2'b01, 0, 0, 0,   0, 0, 0};
        tbl[19] = '{2'b11, 2'b00, 2'b00, 1, 1, 0,   0, 0, 0};
        tbl[20] = '{2'b11, 2'b01, 2'b00, 1, 1, 0,   1, 1, 0};
        tbl[21] = '{2'b11, 2'b00, 2'b00, 1, 1, 0,   0, 0, 255};
        tbl[22] = '{2'b10, 2'b10, 2'b00, 2, 2, 0,   9, 0, 255};

        st[0] = 2'b11; st[1] = 2'b11;
        for (int k = 0; k < 3; k++) for (int c = 0; c < 2; c++) begin
            m_val[k][c] = 0; m_dir[k][c] = 0; exp_val[k][c] = 0;
            exp_steps[k][c] = 0; exp_errs[k][c] = 0;
        end

        // Reset with toggling encoder inputs.
        rst_n = 1'b0; a = 2'b00; b = 2'b00; clear = 2'b00;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            a = a ^ 2'(i + 1); b = b ^ 2'(i + 2);
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset dut%0d value", k), int'(val[k]), 0);
            chk($sformatf("reset dut%0d step_p", k), int'(stp[k]), 0);
            chk($sformatf("reset dut%0d err_p", k), int'(er[k]), 0);
            chk($sformatf("reset dut%0d dir", k), int'(dr[k]), 0);
        end
        a = 2'b11; b = 2'b11;
        run_cycles(3);
        rst_n = 1'b1;
        zero_counts();
        run_cycles(HOLD);
        check_all("post-reset");
        $display("[TB] reset released, values %0d %0d %0d", val_a, val_b, val_c);

        // Glitch on a[0] lasting exactly three debounce ticks must be ignored.
        zero_counts();
        a[0] = 1'b0;
        run_cycles(12);
        a[0] = 1'b1;
        run_cycles(HOLD);
        check_all("glitch");
        $display("[TB] glitch 3 ticks, values %0d %0d %0d", val_a, val_b, val_c);

        for (int i = 0; i < 23; i++) begin
            apply(tbl[i].ab0, tbl[i].ab1, tbl[i].clr);
            exp_val[0][0] = tbl[i].va0; exp_val[1][0] = tbl[i].vb0; exp_val[2][0] = tbl[i].vc0;
            exp_val[0][1] = tbl[i].va1; exp_val[1][1] = tbl[i].vb1; exp_val[2][1] = tbl[i].vc1;
            check_all($sformatf("vec%0d", i));
            $display("[TB] vec%0d ab0=%b ab1=%b clr=%b -> a=%h b=%h c=%h", i,
                     tbl[i].ab0, tbl[i].ab1, tbl[i].clr, val_a, val_b, val_c);
        end

        for (int i = 0; i < 40; i++) begin
            logic [1:0] nab [2];
            logic [1:0] clr;
            for (int c = 0; c < 2; c++) begin
                int r, p;
                r = int'($urandom_range(0, 9));
                p = gpos(st[c]);
                if (r < 4)      nab[c] = st[c];
                else if (r < 7) nab[c] = gray[(p + 1) % 4];
                else if (r < 9) nab[c] = gray[(p + 3) % 4];
                else            nab[c] = gray[(p + 2) % 4];
                clr[c] = ($urandom_range(0, 9) == 0);
            end
            apply(nab[0], nab[1], clr);
            model_to_exp();
            check_all($sformatf("rnd%0d", i));
            $display("[TB] rnd%0d ab0=%b ab1=%b clr=%b -> a=%h b=%h c=%h", i,
                     nab[0], nab[1], clr, val_a, val_b, val_c);
        end

`ifdef ENC_ACCEL_EN
        // Clear, let the tick count saturate, then four up-steps three ticks apart: 1,4,4,4.
        apply(st[0], st[1], 2'b01);
        model_to_exp();
        check_all("accel-clear");
        zero_counts();
        for (int i = 0; i < 4; i++) begin
            st[0] = gray[(gpos(st[0]) + 1) % 4];
            a[0] = st[0][1];
            b[0] = st[0][0];
            run_cycles(12);
        end
        run_cycles(IDLE);
        m_val[0][0] = 0; m_val[1][0] = 9; m_val[2][0] = 1;
        for (int k = 0; k < 3; k++) begin
            m_dir[k][0] = 1;
            exp_steps[k][1] = 0; exp_errs[k][0] = 0; exp_errs[k][1] = 0;
        end
        exp_steps[0][0] = 4; exp_steps[1][0] = 4; exp_steps[2][0] = 1;
        model_to_exp();
        check_all("accel");
        $display("[TB] accel burst -> a=%h b=%h c=%h", val_a, val_b, val_c);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
